// File: rtl/mux_sched_pkg.sv
// Shared definitions for the 16-requester round-robin mux scheduler:
// sizes, FSM state encoding and a one-hot helper.
package mux_sched_pkg;

  localparam int N     = 16;
  localparam int SEL_W = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from
// ptr+1, wrapping, with ptr itself considered last.
module rr_pick
  import mux_sched_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] start;
  logic [N-1:0]     rot;
  logic [SEL_W-1:0] off;

  // Rotate so bit 0 is the highest-priority slot, fixed-priority find, map back.
  always_comb begin
    start = ptr + SEL_W'(1);
    rot   = '0;
    for (int k = 0; k < N; k++) begin
      rot[k] = req[SEL_W'(start + SEL_W'(k))];
    end
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    idx = start + off;
    any = |req;
  end

endmodule

// File: rtl/mux16_rr_scheduler.sv
// Round-robin scheduler sharing a 16:1 mux among 16 requesters, with grant
// tenure bounded by MAX_HOLD cycles while other requesters are waiting.
module mux16_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [SEL_W-1:0] sel,
  output logic [N-1:0]     gnt,
  output logic             valid,
  output logic             gnt_chg
);

  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic              valid_q, valid_d;
  logic              gnt_chg_q, gnt_chg_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  logic [SEL_W-1:0]  pick_idx;
  logic              pick_any;
  logic              owner_req;
  logic              others_pending;
  logic              do_grant;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // gnt_q is one-hot on the owner in GRANT, so it doubles as the owner mask.
  assign owner_req      = |(req & gnt_q);
  assign others_pending = |(req & ~gnt_q);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    valid_d    = valid_q;
    gnt_chg_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    ptr_d      = ptr_q;
    do_grant   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) do_grant = 1'b1;
      end
      GRANT: begin
        // Release wins over a simultaneous tenure expiry.
        if (!owner_req) begin
          if (others_pending) begin
            do_grant = 1'b1;
          end else begin
            state_d    = IDLE;
            gnt_d      = '0;
            valid_d    = 1'b0;
            hold_cnt_d = '0;
          end
        end else if (hold_cnt_q == HOLD_LAST) begin
          if (others_pending) do_grant = 1'b1;
          else                hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_grant) begin
      state_d    = GRANT;
      sel_d      = pick_idx;
      gnt_d      = onehot(pick_idx);
      valid_d    = 1'b1;
      gnt_chg_d  = 1'b1;
      hold_cnt_d = '0;
      ptr_d      = pick_idx;
    end
  end

  // ptr resets to N-1 so requester 0 has top priority out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      gnt_q      <= '0;
      valid_q    <= 1'b0;
      gnt_chg_q  <= 1'b0;
      hold_cnt_q <= '0;
      ptr_q      <= SEL_W'(N - 1);
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      valid_q    <= valid_d;
      gnt_chg_q  <= gnt_chg_d;
      hold_cnt_q <= hold_cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign valid   = valid_q;
  assign gnt_chg = gnt_chg_q;

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Self-checking bench for mux16_rr_scheduler: directed scenarios plus random
// requests checked against a queue-free arithmetic round-robin model.
module tb_mux16_rr_scheduler;

  localparam int MAX_HOLD = 8;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        valid;
  logic        gnt_chg;

  logic [15:0] mux_i;
  logic        y;

  int n_cmp;
  int n_fail;

  // Reference model: owner as an integer (-1 when idle).
  int m_owner;
  int m_sel;
  int m_ptr;
  int m_hold;
  bit m_chg;

  mux16_rr_scheduler #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .sel     (sel),
    .gnt     (gnt),
    .valid   (valid),
    .gnt_chg (gnt_chg)
  );

  // Behavioural stand-in for the downstream mux16_to_1.
  assign y = mux_i[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick_from(int p, logic [15:0] r);
    for (int k = 1; k <= 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  task automatic model_grant();
    int n;
    n       = pick_from(m_ptr, req);
    m_owner = n;
    m_sel   = n;
    m_ptr   = n;
    m_hold  = 0;
    m_chg   = 1'b1;
  endtask

  task automatic model_update();
    bit others;
    m_chg = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_sel   = 0;
      m_ptr   = 15;
      m_hold  = 0;
    end else if (m_owner < 0) begin
      if (req != 16'h0) model_grant();
    end else begin
      others = (req & ~(16'h1 << m_owner)) != 16'h0;
      if (!req[m_owner]) begin
        if (others) model_grant();
        else begin
          m_owner = -1;
          m_hold  = 0;
        end
      end else if (m_hold == MAX_HOLD - 1) begin
        if (others) model_grant();
        else m_hold = 0;
      end else begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  function automatic logic [21:0] model_vec();
    logic [15:0] g;
    g = (m_owner < 0) ? 16'h0 : (16'h1 << m_owner);
    return {g, 4'(m_sel), (m_owner >= 0), m_chg};
  endfunction

  // One clock: inputs were set after the previous edge; sample #1 after this one.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 16'hFFFF;
    tick();
    tick();
    n_cmp++;
    if (gnt !== 16'h0) begin
      n_fail++; $display("[TB] FAIL reset_gnt got %h want 0000", gnt);
    end
    n_cmp++;
    if (sel !== 4'd0) begin
      n_fail++; $display("[TB] FAIL reset_sel got %0d want 0", sel);
    end
    n_cmp++;
    if (valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_valid got %b want 0", valid);
    end
    n_cmp++;
    if (gnt_chg !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_gnt_chg got %b want 0", gnt_chg);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({sel, gnt, gnt_chg, valid} !== {4'd0, 16'h0001, 1'b1, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL first_grant got sel=%0d gnt=%h chg=%b valid=%b want sel=0 gnt=0001 chg=1 valid=1",
               sel, gnt, gnt_chg, valid);
    end
  endtask

  task automatic test_single_steady();
    int chg_cnt;
    do_reset();
    req     = 16'h0020;
    chg_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (gnt_chg === 1'b1) chg_cnt++;
      n_cmp++;
      if ({sel, gnt} !== {4'd5, 16'h0020}) begin
        n_fail++;
        $display("[TB] FAIL steady_c%0d got sel=%0d gnt=%h want sel=5 gnt=0020", c, sel, gnt);
      end
    end
    n_cmp++;
    if (chg_cnt !== 1) begin
      n_fail++; $display("[TB] FAIL steady_chg_count got %0d want 1", chg_cnt);
    end
  endtask

  task automatic test_two_rotate();
    int exp_sel;
    bit exp_chg;
    do_reset();
    req = 16'h8001;
    for (int c = 1; c <= 32; c++) begin
      tick();
      exp_sel = (((c - 1) / MAX_HOLD) % 2 == 0) ? 0 : 15;
      exp_chg = ((c - 1) % MAX_HOLD) == 0;
      n_cmp++;
      if ({sel, gnt_chg} !== {4'(exp_sel), exp_chg}) begin
        n_fail++;
        $display("[TB] FAIL rotate_c%0d got sel=%0d chg=%b want sel=%0d chg=%b",
                 c, sel, gnt_chg, exp_sel, exp_chg);
      end
    end
  endtask

  task automatic test_wrap();
    int exp_sel;
    do_reset();
    req = 16'h4000;
    tick();
    req = 16'h4003;
    for (int c = 2; c <= 25; c++) begin
      tick();
      exp_sel = (c <= 8) ? 14 : (c <= 16) ? 0 : (c <= 24) ? 1 : 14;
      n_cmp++;
      if (sel !== 4'(exp_sel)) begin
        n_fail++; $display("[TB] FAIL wrap_c%0d got sel=%0d want %0d", c, sel, exp_sel);
      end
      n_cmp++;
      if ({gnt, sel, valid, gnt_chg} !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL wrap_model_c%0d got %h want %h", c, {gnt, sel, valid, gnt_chg}, model_vec());
      end
    end
  endtask

  task automatic test_release_handoff();
    do_reset();
    req = 16'h0008;
    tick();
    tick();
    tick();
    req = 16'h0200;
    tick();
    n_cmp++;
    if ({sel, gnt, gnt_chg} !== {4'd9, 16'h0200, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL handoff got sel=%0d gnt=%h chg=%b want sel=9 gnt=0200 chg=1", sel, gnt, gnt_chg);
    end
    req = 16'h0208;
    for (int c = 2; c <= 8; c++) begin
      tick();
      n_cmp++;
      if (sel !== 4'd9) begin
        n_fail++; $display("[TB] FAIL handoff_hold_c%0d got sel=%0d want 9", c, sel);
      end
    end
    tick();
    n_cmp++;
    if ({sel, gnt_chg} !== {4'd3, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL handoff_expire got sel=%0d chg=%b want sel=3 chg=1", sel, gnt_chg);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 16'h0080;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({gnt, sel, valid} !== {16'h0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL midrst got gnt=%h sel=%0d valid=%b want gnt=0000 sel=0 valid=0", gnt, sel, valid);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({sel, gnt_chg} !== {4'd7, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL midrst_regrant got sel=%0d chg=%b want sel=7 chg=1", sel, gnt_chg);
    end
  endtask

  task automatic test_random();
    int mode;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      mode = $urandom_range(0, 9);
      if (mode == 0)      req = 16'($urandom);
      else if (mode == 1) req = 16'h0;
      else if (mode == 2) req = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      else if (mode == 3) req = req & ~(16'h1 << $urandom_range(0, 15));
      rst = ($urandom_range(0, 79) == 0);
      tick();
      n_cmp++;
      if ({gnt, sel, valid, gnt_chg} !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL random_c%0d got %h want %h (req=%h)", c, {gnt, sel, valid, gnt_chg}, model_vec(), req);
      end
      if (valid === 1'b1) begin
        n_cmp++;
        if (y !== mux_i[m_sel]) begin
          n_fail++; $display("[TB] FAIL mux_y_c%0d got %b want %b", c, y, mux_i[m_sel]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    mux_i   = 16'h1248;
    rst     = 1'b1;
    req     = 16'h0;
    m_owner = -1;
    m_sel   = 0;
    m_ptr   = 15;
    m_hold  = 0;
    m_chg   = 1'b0;
    test_reset();
    test_single_steady();
    test_two_rotate();
    test_wrap();
    test_release_handoff();
    test_reset_mid_grant();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
